// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs_checker
// Brief    : Self-seeding 32-bit PRBS receive checker with lock detection,
//            error pulses and saturating error / checked-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_checker #(
  parameter int STATE_WID   = 32,
  parameter int CNT_WID     = 16,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               data_i,
  input  logic               clear_i,
  output logic               locked_o,
  output logic               err_o,
  output logic [CNT_WID-1:0] err_cnt_o,
  output logic [CNT_WID-1:0] chk_cnt_o
);

  localparam int c_seed_w = $clog2(STATE_WID);
  localparam int c_win_w  = $clog2(WIN_LEN + 1);
  localparam logic [c_seed_w-1:0] c_seed_last = c_seed_w'(STATE_WID - 1);
  localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(WIN_LEN - 1);
  localparam logic [c_win_w-1:0]  c_thresh    = c_win_w'(LOSS_THRESH);

  typedef enum logic [0:0] {
    ST_SEED  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  state_t               r_state;
  logic [STATE_WID-1:0] r_hist;
  logic [c_seed_w-1:0]  r_seed_cnt;
  logic [c_win_w-1:0]   r_win_cnt;
  logic [c_win_w-1:0]   r_win_err;
  logic                 r_locked;
  logic                 r_err;
  logic [CNT_WID-1:0]   r_err_cnt;
  logic [CNT_WID-1:0]   r_chk_cnt;

  logic                 w_exp;
  logic                 w_mis;
  logic [STATE_WID-1:0] w_hist_seed;
  logic [c_win_w-1:0]   w_win_err_nxt;

  // h[0] is the newest bit; taps realise x^32+x^22+x^2+x^1.
  assign w_exp         = r_hist[31] ^ r_hist[21] ^ r_hist[1] ^ r_hist[0];
  assign w_mis         = data_i ^ w_exp;
  assign w_hist_seed   = {r_hist[STATE_WID-2:0], data_i};
  assign w_win_err_nxt = r_win_err + {{(c_win_w-1){1'b0}}, w_mis};

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_SEED;
      r_hist     <= '0;
      r_seed_cnt <= '0;
      r_win_cnt  <= '0;
      r_win_err  <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_chk_cnt  <= '0;
    end else begin
      r_err <= 1'b0;
      if (valid_i) begin
        case (r_state)
          ST_SEED: begin
            r_hist <= w_hist_seed;
            if (r_seed_cnt == c_seed_last) begin
              r_seed_cnt <= '0;
              // An all-zero history would predict zeros forever; keep seeding.
              if (w_hist_seed != '0) begin
                r_state   <= ST_CHECK;
                r_locked  <= 1'b1;
                r_win_cnt <= '0;
                r_win_err <= '0;
              end
            end else begin
              r_seed_cnt <= r_seed_cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            // Reference free-runs on its own prediction, not on received data.
            r_hist <= {r_hist[STATE_WID-2:0], w_exp};
            r_err  <= w_mis;
            if (r_chk_cnt != '1)
              r_chk_cnt <= r_chk_cnt + 1'b1;
            if (w_mis && (r_err_cnt != '1))
              r_err_cnt <= r_err_cnt + 1'b1;
            if (w_win_err_nxt >= c_thresh) begin
              r_state    <= ST_SEED;
              r_locked   <= 1'b0;
              r_seed_cnt <= '0;
              r_win_cnt  <= '0;
              r_win_err  <= '0;
            end else if (r_win_cnt == c_win_last) begin
              r_win_cnt <= '0;
              r_win_err <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + 1'b1;
              r_win_err <= w_win_err_nxt;
            end
          end
          default: r_state <= ST_SEED;
        endcase
      end
      // Clear overrides any increment made above on the same beat.
      if (clear_i) begin
        r_err_cnt <= '0;
        r_chk_cnt <= '0;
      end
    end
  end

  assign locked_o  = r_locked;
  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;
  assign chk_cnt_o = r_chk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs_checker
// Brief    : Randomised self-checking bench for prbs_checker against a
//            queue-based behavioural model of the receive checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_checker;

  localparam int c_cnt_max = 65535;
  localparam int c_slen    = 1200;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        data_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        locked_o;
  logic        err_o;
  logic [15:0] err_cnt_o;
  logic [15:0] chk_cnt_o;

  prbs_checker #(
    .STATE_WID  (32),
    .CNT_WID    (16),
    .WIN_LEN    (64),
    .LOSS_THRESH(8)
  ) dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .clear_i  (clear_i),
    .locked_o (locked_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o),
    .chk_cnt_o(chk_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int saw_err  = 0;
  int saw_unlock = 0;

  bit stream [c_slen];

  // Behavioural model state
  int m_locked, m_err, m_err_cnt, m_chk_cnt, win_beats, win_errs;
  bit seedq[$];
  bit refq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_err = 0; m_err_cnt = 0; m_chk_cnt = 0;
    win_beats = 0; win_errs = 0;
    seedq.delete();
    refq.delete();
  endtask

  task automatic model_step(input bit v, input bit d, input bit clr);
    int  n;
    bit  e, mis, any1;
    m_err = 0;
    if (v) begin
      if (m_locked == 0) begin
        seedq.push_back(d);
        if (seedq.size() == 32) begin
          any1 = 0;
          foreach (seedq[k]) any1 |= seedq[k];
          if (any1) begin
            m_locked = 1;
            refq = seedq;
            win_beats = 0; win_errs = 0;
          end
          seedq.delete();
        end
      end else begin
        n = refq.size();
        e = refq[n-32] ^ refq[n-22] ^ refq[n-2] ^ refq[n-1];
        refq.push_back(e);
        void'(refq.pop_front());
        mis = d ^ e;
        m_err = mis;
        if (!clr) begin
          if (m_chk_cnt < c_cnt_max) m_chk_cnt++;
          if (mis && m_err_cnt < c_cnt_max) m_err_cnt++;
        end
        win_beats++;
        win_errs += mis;
        if (win_errs >= 8) begin
          m_locked = 0;
          seedq.delete();
          win_beats = 0; win_errs = 0;
        end else if (win_beats == 64) begin
          win_beats = 0; win_errs = 0;
        end
      end
    end
    if (clr) begin
      m_err_cnt = 0; m_chk_cnt = 0;
    end
  endtask

  task automatic beat(input bit v, input bit d, input bit clr);
    valid_i = v; data_i = d; clear_i = clr;
    @(posedge clk); #1;
    model_step(v, d, clr);
    if (err_o === 1'b1) saw_err++;
    if (locked_o !== 1'b1) saw_unlock++;
    check("locked", locked_o, m_locked);
    check("err", err_o, m_err);
    check("err_cnt", err_cnt_o, m_err_cnt);
    check("chk_cnt", chk_cnt_o, m_chk_cnt);
  endtask

  task automatic do_reset();
    valid_i = 0; data_i = 0; clear_i = 0;
    rst_i = 1;
    @(posedge clk); #1;
    rst_i = 0;
    model_reset();
    check("rst_locked", locked_o, 0);
    check("rst_err", err_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
    check("rst_chk_cnt", chk_cnt_o, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 1'($urandom), 0);
  endtask

  initial begin
    logic [31:0] seed_v;
    int idx, cyc;
    bit v;

    seed_v = 32'd1;
    for (int i = 0; i < 32; i++) stream[i] = seed_v[31-i];
    for (int i = 32; i < c_slen; i++)
      stream[i] = stream[i-32] ^ stream[i-22] ^ stream[i-2] ^ stream[i-1];

    // Clean stream
    do_reset();
    saw_err = 0;
    for (int i = 0; i < 1032; i++) begin
      beat(1, stream[i], 0);
      if (i == 30) check("s1_not_locked_yet", locked_o, 0);
      if (i == 31) check("s1_locked_after_32", locked_o, 1);
    end
    check("s1_chk_cnt", chk_cnt_o, 1000);
    check("s1_err_cnt", err_cnt_o, 0);
    check("s1_no_err", saw_err, 0);

    // Single flipped bit
    do_reset();
    saw_err = 0;
    for (int i = 0; i < 1032; i++) begin
      beat(1, stream[i] ^ (i == 200), 0);
      if (i == 200) check("s2_err_pulse", err_o, 1);
      if (i == 201) check("s2_err_single", err_o, 0);
      if (i == 40) saw_unlock = 0;
    end
    check("s2_err_cnt", err_cnt_o, 1);
    check("s2_chk_cnt", chk_cnt_o, 1000);
    check("s2_one_pulse", saw_err, 1);
    check("s2_stays_locked", saw_unlock, 0);

    // Eight errors in one window -> loss and relock
    do_reset();
    for (int i = 0; i < 160; i++) begin
      beat(1, stream[i] ^ (i >= 40 && i <= 54 && i[0] == 1'b0), 0);
      if (i == 53) check("s3_locked_before_8th", locked_o, 1);
      if (i == 54) check("s3_unlock_after_8th", locked_o, 0);
      if (i == 85) check("s3_not_relocked_yet", locked_o, 0);
      if (i == 86) check("s3_relock", locked_o, 1);
    end
    check("s3_err_cnt", err_cnt_o, 8);

    // Seven errors in each of two windows -> no loss
    do_reset();
    for (int i = 0; i < 200; i++) begin
      beat(1, stream[i] ^ ((i >= 40 && i < 47) || (i >= 100 && i < 107)), 0);
      if (i == 40) saw_unlock = 0;
    end
    check("s4_err_cnt", err_cnt_o, 14);
    check("s4_never_unlock", saw_unlock, 0);

    // Degenerate zero stream, then proper stream
    do_reset();
    for (int i = 0; i < 40; i++) beat(1, 0, 0);
    check("s5_zero_unlocked", locked_o, 0);
    check("s5_zero_chk", chk_cnt_o, 0);
    for (int i = 0; i < 120; i++) beat(1, stream[i], 0);
    check("s5_locked", locked_o, 1);
    check("s5_err_cnt", err_cnt_o, 0);

    // Random valid gaps with random idle data
    do_reset();
    idx = 0; cyc = 0;
    while (idx < 1032 && cyc < 10000) begin
      v = 1'($urandom);
      if (v) begin
        beat(1, stream[idx], 0);
        idx++;
      end else begin
        beat(0, 1'($urandom), 0);
      end
      cyc++;
    end
    check("s6_all_fed", idx, 1032);
    check("s6_chk_cnt", chk_cnt_o, 1000);
    check("s6_err_cnt", err_cnt_o, 0);
    idle(3);

    // Clear on a mismatching beat
    do_reset();
    for (int i = 0; i < 40; i++) beat(1, stream[i], 0);
    beat(1, stream[40] ^ 1'b1, 1);
    check("s7_err_pulse", err_o, 1);
    check("s7_err_cnt_cleared", err_cnt_o, 0);
    check("s7_chk_cnt_cleared", chk_cnt_o, 0);
    check("s7_still_locked", locked_o, 1);
    for (int i = 41; i < 60; i++) beat(1, stream[i], 0);
    check("s7_chk_after", chk_cnt_o, 19);

    // Random clears and flips mixed in
    do_reset();
    for (int i = 0; i < 400; i++)
      beat(1'($urandom_range(0, 3) != 0), stream[i] ^ ($urandom_range(0, 40) == 0),
           $urandom_range(0, 60) == 0);

    // Asynchronous reset mid-CHECK
    do_reset();
    for (int i = 0; i < 50; i++) beat(1, stream[i] ^ (i == 49), 0);
    check("s8_pre_err", err_o, 1);
    #2 rst_i = 1;
    #1;
    check("s8_async_locked", locked_o, 0);
    check("s8_async_err", err_o, 0);
    check("s8_async_err_cnt", err_cnt_o, 0);
    check("s8_async_chk_cnt", chk_cnt_o, 0);
    @(posedge clk); #1;
    rst_i = 0;
    model_reset();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
